// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//   Shares the single data port of the CPU data RAM between the CPU
//   load/store path and one external bus master (loader/DMA/display).
//   The CPU normally has priority. A starvation guard forces the device ahead
//   after STARVE_MAX denied cycles, and a locked device burst may hold the
//   port for up to BURST_MAX cycles. Read data (one-cycle RAM latency) is
//   routed back to whichever requester issued the read.
//
// Ports
//   clk, rst                          clock, synchronous active-high reset
//   cpu_req/we/addr/wdata             CPU request
//   cpu_gnt                           CPU access accepted this cycle
//   cpu_rvalid/cpu_rdata              read return for the CPU
//   dev_req/we/addr/wdata, dev_lock   device request, burst lock
//   dev_gnt, dev_rvalid, dev_rdata    device grant and read return
//   mem_we/addr/wdata                 RAM port, driven by the winner
//   mem_rdata                         RAM read data, one cycle after address
module ram_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4,
  parameter int BURST_MAX  = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dev_req,
  input  logic          dev_we,
  input  logic [AW-1:0] dev_addr,
  input  logic [DW-1:0] dev_wdata,
  input  logic          dev_lock,
  output logic          dev_gnt,
  output logic          dev_rvalid,
  output logic [DW-1:0] dev_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int BW = $clog2(BURST_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [BW-1:0] BURST_LIM  = BW'(BURST_MAX);

  typedef enum logic {ARB, DEV_BURST} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_DEV} own_t;

  state_t        state, state_nx;
  logic [SW-1:0] starve_cnt, starve_cnt_nx;
  logic [BW-1:0] burst_cnt, burst_cnt_nx;
  logic [BW-1:0] burst_inc;
  logic          cpu_prio, cpu_prio_nx;
  own_t          rd_own, rd_own_nx;
  logic          burst_hold;
  logic          cpu_win, dev_win;

  // State register: control only, no data is held here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ARB;
      starve_cnt <= '0;
      burst_cnt  <= '0;
      cpu_prio   <= 1'b0;
      rd_own     <= OWN_NONE;
    end else begin
      state      <= state_nx;
      starve_cnt <= starve_cnt_nx;
      burst_cnt  <= burst_cnt_nx;
      cpu_prio   <= cpu_prio_nx;
      rd_own     <= rd_own_nx;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx     = ARB;
    burst_cnt_nx = burst_cnt;
    cpu_prio_nx  = 1'b0;
    burst_inc    = burst_cnt + 1'b1;
    if (burst_hold) begin
      // Burst continues; end it once this grant brings the count to the limit.
      burst_cnt_nx = burst_inc;
      if (burst_inc == BURST_LIM) begin
        cpu_prio_nx = 1'b1;
      end else begin
        state_nx = DEV_BURST;
      end
    end else if (dev_win && dev_lock) begin
      // The granting ARB cycle is the first cycle of the burst.
      burst_cnt_nx = BW'(1);
      if (BURST_LIM == BW'(1)) begin
        cpu_prio_nx = 1'b1;
      end else begin
        state_nx = DEV_BURST;
      end
    end

    if (dev_req && !dev_win) begin
      starve_cnt_nx = (starve_cnt == STARVE_LIM) ? starve_cnt : starve_cnt + 1'b1;
    end else begin
      starve_cnt_nx = '0;
    end

    if (cpu_win && !cpu_we) begin
      rd_own_nx = OWN_CPU;
    end else if (dev_win && !dev_we) begin
      rd_own_nx = OWN_DEV;
    end else begin
      rd_own_nx = OWN_NONE;
    end
  end

  // Output logic: winner selection, RAM port mux and read-return routing.
  always_comb begin
    // A burst that drops lock or request falls back to normal arbitration
    // in the same cycle.
    burst_hold = (state == DEV_BURST) && dev_req && dev_lock;
    cpu_win    = 1'b0;
    dev_win    = 1'b0;
    if (burst_hold) begin
      dev_win = 1'b1;
    end else if (dev_req && (starve_cnt == STARVE_LIM) && !cpu_prio) begin
      dev_win = 1'b1;
    end else if (cpu_req) begin
      cpu_win = 1'b1;
    end else if (dev_req) begin
      dev_win = 1'b1;
    end

    cpu_gnt = cpu_win;
    dev_gnt = dev_win;

    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_win) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (dev_win) begin
      mem_we    = dev_we;
      mem_addr  = dev_addr;
      mem_wdata = dev_wdata;
    end

    cpu_rvalid = (rd_own == OWN_CPU);
    dev_rvalid = (rd_own == OWN_DEV);
    cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
    dev_rdata  = dev_rvalid ? mem_rdata : '0;
  end

endmodule
